sprite_motion_ctrl: RTL

Frame-synchronous position and variant controller for the image sprite. Watches the pixel counters and detects the start of vertical blanking. During blanking it advances the sprite's top-left corner with edge bounce and applies pending variant (pop) toggles. It drives the sprite renderer's `x_in`, `y_in` and `pop` inputs, so they never change mid-frame.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_motion_ctrl_axis_step.sv | 42 ++++
 rtl/sprite_motion_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion controller: default video timing
// and the frame-update FSM state encoding.
package sprite_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// Combinational next-position / next-direction for one axis with edge bounce.
// The sum is formed at 12 bits so position plus step can never wrap.
module axis_step #(
    parameter int W    = 11,
    parameter int STEP = 4,
    parameter int MAX  = 1024
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    output logic [W-1:0] next_pos,
    output logic         next_dir
);

    logic [11:0] pos_ext;
    logic [11:0] sum;
    logic [11:0] diff;

    always_comb begin
        pos_ext  = 12'(pos);
        sum      = pos_ext + 12'(STEP);
        diff     = pos_ext - 12'(STEP);
        next_pos = pos;
        next_dir = dir;
        if (dir) begin
            if (sum >= 12'(MAX)) begin
                next_pos = W'(MAX);
                next_dir = 1'b0;
            end else begin
                next_pos = sum[W-1:0];
            end
        end else begin
            // Landing exactly on the step distance also bounces, so 0 is reached.
            if (pos_ext <= 12'(STEP)) begin
                next_pos = '0;
                next_dir = 1'b1;
            end else begin
                next_pos = diff[W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position / variant controller; updates only in vertical blanking.
// Optional feature: define SPRITE_MOTION_PAUSE_EN to honour pause_in.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int WIDTH    = 256,
    parameter int HEIGHT   = 256,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pop_req_in,
    input  logic        pause_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        pop_out,
    output logic        frame_tick_out
);

    localparam int XMAX = H_ACTIVE - WIDTH;
    localparam int YMAX = V_ACTIVE - HEIGHT;

    motion_state_t state;
    motion_state_t next_state;

    logic        dir_x;
    logic        dir_y;
    logic [10:0] nx;
    logic [9:0]  ny;
    logic        ndx;
    logic        ndy;
    logic        pop_pending;
    logic [10:0] step_x;
    logic [9:0]  step_y;
    logic        step_dx;
    logic        step_dy;
    logic        boundary;
    logic        hold;

`ifdef SPRITE_MOTION_PAUSE_EN
    assign hold = pause_in;
`else
    logic unused_pause;
    assign unused_pause = pause_in;
    assign hold         = 1'b0;
`endif

    assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

    axis_step #(.W(11), .STEP(STEP_X), .MAX(XMAX)) u_step_x (
        .pos      (x_out),
        .dir      (dir_x),
        .next_pos (step_x),
        .next_dir (step_dx)
    );

    axis_step #(.W(10), .STEP(STEP_Y), .MAX(YMAX)) u_step_y (
        .pos      (y_out),
        .dir      (dir_y),
        .next_pos (step_y),
        .next_dir (step_dy)
    );

    always_comb begin
        next_state = state;
        case (state)
            WAIT:    if (boundary) next_state = CALC;
            CALC:    next_state = COMMIT;
            COMMIT:  next_state = WAIT;
            default: next_state = WAIT;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Shadow values are computed in CALC and published together in COMMIT.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            nx             <= '0;
            ny             <= '0;
            ndx            <= 1'b1;
            ndy            <= 1'b1;
            dir_x          <= 1'b1;
            dir_y          <= 1'b1;
            x_out          <= '0;
            y_out          <= '0;
            pop_out        <= 1'b0;
            pop_pending    <= 1'b0;
            frame_tick_out <= 1'b0;
        end else begin
            frame_tick_out <= 1'b0;
            pop_pending    <= pop_pending | pop_req_in;
            if (state == CALC) begin
                nx  <= hold ? x_out : step_x;
                ny  <= hold ? y_out : step_y;
                ndx <= hold ? dir_x : step_dx;
                ndy <= hold ? dir_y : step_dy;
            end
            if (state == COMMIT) begin
                x_out          <= nx;
                y_out          <= ny;
                dir_x          <= ndx;
                dir_y          <= ndy;
                pop_out        <= pop_out ^ (pop_pending | pop_req_in);
                pop_pending    <= 1'b0;
                frame_tick_out <= 1'b1;
            end
        end
    end

endmodule
